// File: rtl/nap_timer_ctrl.sv
// Nap timer controller: owns the six-digit BCD HH:MM:SS register and sequences set/normalize/run/alarm.
// Latency: every output is registered and updates on the edge that samples the input strobe.
// Backpressure: none; strobes arriving while busy (NORM) are dropped, never queued.
module nap_timer_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       sharp,
  input  logic       star,
  input  logic       tick,
  output logic [3:0] hour10,
  output logic [3:0] hour1,
  output logic [3:0] minute10,
  output logic [3:0] minute1,
  output logic [3:0] second10,
  output logic [3:0] second1,
  output logic [2:0] state,
  output logic       busy,
  output logic       alarm
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_ALARM = 3'd5;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

  logic [2:0] state_q, state_d;
  logic       busy_q, busy_d;
  logic       alarm_q, alarm_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] h10_q, h1_q, m10_q, m1_q, s10_q, s1_q;
  logic [3:0] h10_d, h1_d, m10_d, m1_d, s10_d, s1_d;

  // Keypad decode results
  logic       key_vld;
  logic [3:0] key_idx;
  logic       key_add;

  // Decrement-by-one-second results
  logic [3:0] dh10, dh1, dm10, dm1, ds10, ds1;
  logic       bor1, bor2, bor3, bor4, bor5;
  logic       dec_zero;

  // One normalizer step results
  logic [3:0] nh10, nh1, nm10, nm1, ns10, ns1;
  logic       norm_done;

  logic       time_zero;
  logic [7:0] cnt_inc;

  assign time_zero = (h10_q == 4'd0) && (h1_q == 4'd0) && (m10_q == 4'd0) &&
                     (m1_q == 4'd0) && (s10_q == 4'd0) && (s1_q == 4'd0);
  assign cnt_inc   = cnt_q + 8'd1;
  assign key_add   = key_vld && ((key_idx == 4'd1) || (key_idx == 4'd2) || (key_idx == 4'd3));

  // A key counts only when exactly one keypad bit is set; report its index
  always_comb begin
    key_vld = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    key_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_idx = 4'(i);
    end
  end

  // Subtract one second with a full BCD borrow chain (caller guarantees time != 0)
  always_comb begin
    bor1 = (s1_q == 4'd0);
    ds1  = bor1 ? 4'd9 : s1_q - 4'd1;
    bor2 = bor1 && (s10_q == 4'd0);
    ds10 = bor1 ? ((s10_q == 4'd0) ? 4'd5 : s10_q - 4'd1) : s10_q;
    bor3 = bor2 && (m1_q == 4'd0);
    dm1  = bor2 ? ((m1_q == 4'd0) ? 4'd9 : m1_q - 4'd1) : m1_q;
    bor4 = bor3 && (m10_q == 4'd0);
    dm10 = bor3 ? ((m10_q == 4'd0) ? 4'd5 : m10_q - 4'd1) : m10_q;
    bor5 = bor4 && (h1_q == 4'd0);
    dh1  = bor4 ? ((h1_q == 4'd0) ? 4'd9 : h1_q - 4'd1) : h1_q;
    dh10 = bor5 ? ((h10_q == 4'd0) ? 4'd9 : h10_q - 4'd1) : h10_q;
    dec_zero = (dh10 == 4'd0) && (dh1 == 4'd0) && (dm10 == 4'd0) &&
               (dm1 == 4'd0) && (ds10 == 4'd0) && (ds1 == 4'd0);
  end

  // Fix the lowest out-of-range digit; done once the fixed value is fully in range
  always_comb begin
    nh10 = h10_q;
    nh1  = h1_q;
    nm10 = m10_q;
    nm1  = m1_q;
    ns10 = s10_q;
    ns1  = s1_q;
    if (s1_q > 4'd9) begin
      ns1  = s1_q - 4'd10;
      ns10 = s10_q + 4'd1;
    end else if (s10_q > 4'd5) begin
      ns10 = s10_q - 4'd6;
      nm1  = m1_q + 4'd1;
    end else if (m1_q > 4'd9) begin
      nm1  = m1_q - 4'd10;
      nm10 = m10_q + 4'd1;
    end else if (m10_q > 4'd5) begin
      nm10 = m10_q - 4'd6;
      nh1  = h1_q + 4'd1;
    end else if (h1_q > 4'd9) begin
      nh1  = h1_q - 4'd10;
      nh10 = h10_q + 4'd1;
    end else if (h10_q > 4'd9) begin
      // Hour tens overflow: clamp to the largest displayable time
      nh10 = 4'd9;
      nh1  = 4'd9;
      nm10 = 4'd5;
      nm1  = 4'd9;
      ns10 = 4'd5;
      ns1  = 4'd9;
    end
    norm_done = (nh10 <= 4'd9) && (nh1 <= 4'd9) && (nm10 <= 4'd5) &&
                (nm1 <= 4'd9) && (ns10 <= 4'd5) && (ns1 <= 4'd9);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection, priority star > sharp > keypad > tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (star) state_d = S_SET;
      S_SET: begin
        if (star)         state_d = S_IDLE;
        else if (sharp) begin
          if (!time_zero) state_d = S_RUN;
        end
        else if (key_add) state_d = S_NORM;
      end
      S_NORM:  if (norm_done) state_d = S_SET;
      S_RUN: begin
        if (star)                  state_d = S_IDLE;
        else if (sharp)            state_d = S_PAUSE;
        else if (tick && dec_zero) state_d = S_ALARM;
      end
      S_PAUSE: begin
        if (star)       state_d = S_IDLE;
        else if (sharp) state_d = S_RUN;
      end
      S_ALARM: begin
        if (star || sharp || key_vld)            state_d = S_IDLE;
        else if (tick && (cnt_inc == ALARM_LIMIT)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags follow the upcoming state so they line up with the state output
  always_comb begin
    busy_d  = (state_d == S_NORM);
    alarm_d = (state_d == S_ALARM);
  end

  // Status flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      alarm_q <= alarm_d;
    end
  end

  // Time register and alarm counter updates for the current state and inputs
  always_comb begin
    logic clr;
    clr   = 1'b0;
    h10_d = h10_q;
    h1_d  = h1_q;
    m10_d = m10_q;
    m1_d  = m1_q;
    s10_d = s10_q;
    s1_d  = s1_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: clr = 1'b1;
      S_SET: begin
        if (star) clr = 1'b1;
        else if (!sharp && key_vld) begin
          case (key_idx)
            4'd0:    clr   = 1'b1;
            4'd1:    s1_d  = s1_q + 4'd5;
            4'd2:    s10_d = s10_q + 4'd3;
            4'd3:    m1_d  = m1_q + 4'd1;
            default: ;
          endcase
        end
      end
      S_NORM: begin
        h10_d = nh10;
        h1_d  = nh1;
        m10_d = nm10;
        m1_d  = nm1;
        s10_d = ns10;
        s1_d  = ns1;
      end
      S_RUN: begin
        if (star) clr = 1'b1;
        else if (!sharp && tick) begin
          h10_d = dh10;
          h1_d  = dh1;
          m10_d = dm10;
          m1_d  = dm1;
          s10_d = ds10;
          s1_d  = ds1;
          if (dec_zero) cnt_d = 8'd0;
        end
      end
      S_PAUSE: if (star) clr = 1'b1;
      S_ALARM: if (!(star || sharp || key_vld) && tick) cnt_d = cnt_inc;
      default: clr = 1'b1;
    endcase
    if (clr) begin
      h10_d = 4'd0;
      h1_d  = 4'd0;
      m10_d = 4'd0;
      m1_d  = 4'd0;
      s10_d = 4'd0;
      s1_d  = 4'd0;
    end
  end

  // Time register and alarm counter storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h10_q <= 4'd0;
      h1_q  <= 4'd0;
      m10_q <= 4'd0;
      m1_q  <= 4'd0;
      s10_q <= 4'd0;
      s1_q  <= 4'd0;
      cnt_q <= 8'd0;
    end else begin
      h10_q <= h10_d;
      h1_q  <= h1_d;
      m10_q <= m10_d;
      m1_q  <= m1_d;
      s10_q <= s10_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end

  assign hour10   = h10_q;
  assign hour1    = h1_q;
  assign minute10 = m10_q;
  assign minute1  = m1_q;
  assign second10 = s10_q;
  assign second1  = s1_q;
  assign state    = state_q;
  assign busy     = busy_q;
  assign alarm    = alarm_q;

endmodule
